uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_if.sv | 10 +
 rtl/uart_transmitter.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Character handshake between a host and the UART transmitter.
// The host drives dataIn/sendReq; the transmitter answers with ready (holding register empty).
interface uart_transmitter_if;
  logic [7:0] dataIn;
  logic       sendReq;
  logic       ready;

  modport master (output dataIn, output sendReq, input ready);
  modport slave  (input dataIn, input sendReq, output ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: one-entry holding register feeding a shifter with programmable framing.
// Define UART_TX_BREAK_EN to compile in line-break generation (BREAK state).
module uart_transmitter (
  input  logic              clk,
  input  logic              rst,
  uart_transmitter_if.slave host,
  input  logic [1:0]        dataBits,
  input  logic              hasParity,
  input  logic [1:0]        parityMode,
  input  logic              extraStopBit,
  input  logic [23:0]       clockDivisor,
  input  logic              sendBreak,
  output logic              tx,
  output logic              busy
);
  // state  | meaning
  // IDLE   | line high, waiting for the holding register to fill
  // START  | start bit, line low
  // DATA   | data bits, LSB first
  // PARITY | optional parity bit
  // STOP1  | first stop bit
  // STOP2  | optional second stop bit
  // BREAK  | line held low, then one mark bit period before resuming
`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`endif

  state_t      state, stateNext;
  logic        holdFull, holdFullNext;
  logic [7:0]  holdData, holdDataNext;
  logic [7:0]  shiftReg, shiftNext;
  logic [23:0] bitCnt, bitCntNext;
  logic [2:0]  dataLeft, dataLeftNext;
  logic        parityBit, parityNext;
  logic [1:0]  cfgBits, cfgBitsNext;
  logic        cfgParity, cfgParityNext;
  logic        cfgStop2, cfgStop2Next;
  logic [23:0] cfgDiv, cfgDivNext;
  logic        txNext;

  logic [23:0] divIn;
  logic [7:0]  dataMask;
  logic        dataXor;
  logic        parityIn;
  logic        bitEnd;
  logic        startFrame;
  logic        frameDone;

  assign divIn     = (clockDivisor == 24'd0) ? 24'd1 : clockDivisor;
  assign dataMask  = 8'hFF >> (2'd3 - dataBits);
  assign dataXor   = ^(holdData & dataMask);
  assign bitEnd    = (bitCnt == 24'd0);
  assign host.ready = ~holdFull;
  assign busy      = (state != IDLE);

  // Parity is resolved once at frame start, so parityMode needs no separate latch.
  always_comb begin
    case (parityMode)
      2'd0:    parityIn = dataXor;
      2'd1:    parityIn = ~dataXor;
      2'd2:    parityIn = 1'b1;
      default: parityIn = 1'b0;
    endcase
  end

`ifdef UART_TX_BREAK_EN
  logic [27:0] breakCnt, breakCntNext;
  logic        breakMark, breakMarkNext;
  logic [3:0]  frameBitsIn;
  logic [27:0] frameClocksIn;

  assign frameBitsIn   = 4'd7 + {2'b00, dataBits} + {3'b000, hasParity} + {3'b000, extraStopBit};
  assign frameClocksIn = {4'd0, divIn} * {24'd0, frameBitsIn};
`else
  logic unusedSendBreak;
  assign unusedSendBreak = sendBreak;
`endif

  always_comb begin
    stateNext     = state;
    holdFullNext  = holdFull;
    holdDataNext  = holdData;
    shiftNext     = shiftReg;
    bitCntNext    = bitCnt;
    dataLeftNext  = dataLeft;
    parityNext    = parityBit;
    cfgBitsNext   = cfgBits;
    cfgParityNext = cfgParity;
    cfgStop2Next  = cfgStop2;
    cfgDivNext    = cfgDiv;
    startFrame    = 1'b0;
    frameDone     = 1'b0;
    txNext        = 1'b1;
`ifdef UART_TX_BREAK_EN
    breakCntNext  = breakCnt;
    breakMarkNext = breakMark;
`endif

    if (host.sendReq && !holdFull) begin
      holdFullNext = 1'b1;
      holdDataNext = host.dataIn;
    end

    if (state inside {START, DATA, PARITY, STOP1, STOP2})
      bitCntNext = bitEnd ? cfgDiv - 24'd1 : bitCnt - 24'd1;

    case (state)
      IDLE:   frameDone = 1'b1;
      START:  if (bitEnd) begin
                stateNext    = DATA;
                dataLeftNext = {1'b1, cfgBits};
              end
      DATA:   if (bitEnd) begin
                if (dataLeft == 3'd0) begin
                  stateNext = cfgParity ? PARITY : STOP1;
                end else begin
                  shiftNext    = {1'b0, shiftReg[7:1]};
                  dataLeftNext = dataLeft - 3'd1;
                end
              end
      PARITY: if (bitEnd) stateNext = STOP1;
      STOP1:  if (bitEnd) begin
                if (cfgStop2) stateNext = STOP2;
                else          frameDone = 1'b1;
              end
      STOP2:  if (bitEnd) frameDone = 1'b1;
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!breakMark) begin
          if (breakCnt != 28'd0) begin
            breakCntNext = breakCnt - 28'd1;
          end else if (!sendBreak) begin
            breakMarkNext = 1'b1;
            bitCntNext    = cfgDiv - 24'd1;
          end
        end else if (bitEnd) begin
          breakMarkNext = 1'b0;
          stateNext     = IDLE;
          startFrame    = holdFull;
        end else begin
          bitCntNext = bitCnt - 24'd1;
        end
      end
`endif
      default: stateNext = IDLE;
    endcase

    // IDLE and the end of the last stop bit share one decision point, giving back-to-back frames.
    if (frameDone) begin
      stateNext  = IDLE;
      bitCntNext = 24'd0;
      startFrame = holdFull;
`ifdef UART_TX_BREAK_EN
      if (sendBreak) begin
        startFrame    = 1'b0;
        stateNext     = BREAK;
        breakMarkNext = 1'b0;
        breakCntNext  = frameClocksIn - 28'd1;
        cfgBitsNext   = dataBits;
        cfgParityNext = hasParity;
        cfgStop2Next  = extraStopBit;
        cfgDivNext    = divIn;
      end
`endif
    end

    if (startFrame) begin
      stateNext     = START;
      holdFullNext  = 1'b0;
      shiftNext     = holdData;
      parityNext    = parityIn;
      cfgBitsNext   = dataBits;
      cfgParityNext = hasParity;
      cfgStop2Next  = extraStopBit;
      cfgDivNext    = divIn;
      bitCntNext    = divIn - 24'd1;
    end

    case (stateNext)
      START:  txNext = 1'b0;
      DATA:   txNext = shiftNext[0];
      PARITY: txNext = parityNext;
`ifdef UART_TX_BREAK_EN
      BREAK:  txNext = breakMarkNext;
`endif
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      holdFull  <= 1'b0;
      holdData  <= 8'd0;
      shiftReg  <= 8'd0;
      bitCnt    <= 24'd0;
      dataLeft  <= 3'd0;
      parityBit <= 1'b0;
      cfgBits   <= 2'd0;
      cfgParity <= 1'b0;
      cfgStop2  <= 1'b0;
      cfgDiv    <= 24'd0;
      tx        <= 1'b1;
    end else begin
      state     <= stateNext;
      holdFull  <= holdFullNext;
      holdData  <= holdDataNext;
      shiftReg  <= shiftNext;
      bitCnt    <= bitCntNext;
      dataLeft  <= dataLeftNext;
      parityBit <= parityNext;
      cfgBits   <= cfgBitsNext;
      cfgParity <= cfgParityNext;
      cfgStop2  <= cfgStop2Next;
      cfgDiv    <= cfgDivNext;
      tx        <= txNext;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      breakCnt  <= 28'd0;
      breakMark <= 1'b0;
    end else begin
      breakCnt  <= breakCntNext;
      breakMark <= breakMarkNext;
    end
  end
`endif
endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: per-cycle frame-timeline model plus literal waveform checks.
module tb_uart_transmitter;
  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dataBits;
  logic        hasParity;
  logic [1:0]  parityMode;
  logic        extraStopBit;
  logic [23:0] clockDivisor;
  logic        sendBreak;
  logic        tx;
  logic        busy;

  uart_transmitter_if ifc ();

  uart_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .host         (ifc),
    .dataBits     (dataBits),
    .hasParity    (hasParity),
    .parityMode   (parityMode),
    .extraStopBit (extraStopBit),
    .clockDivisor (clockDivisor),
    .sendBreak    (sendBreak),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passCount = 0;
  int checkCount = 0;

  task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  // Expected line timeline: absolute cycle -> tx / busy; absent entries mean idle (tx=1, busy=0).
  bit   expTx[int];
  bit   expBusy[int];
  int   holdUntil = 0;
  int   frameEnd = 0;
  logic txLog [LOGN];
  logic busyLog [LOGN];
  logic readyLog [LOGN];

  int   mD, mS, mW, mN;
  bit   mPx;
  bit   mBits[$];
  logic eTx, eBusy, eReady;

  initial forever begin
    @(negedge clk);
    if (cyc < LOGN) begin
      txLog[cyc] = tx;
      busyLog[cyc] = busy;
      readyLog[cyc] = ifc.ready;
    end
    if (rst) begin
      expTx.delete();
      expBusy.delete();
      holdUntil = 0;
      frameEnd = 0;
    end else begin
      eTx    = expTx.exists(cyc) ? expTx[cyc] : 1'b1;
      eBusy  = expBusy.exists(cyc) ? expBusy[cyc] : 1'b0;
      eReady = (cyc >= holdUntil);
      checkEq($sformatf("tx@%0d", cyc), tx, eTx);
      checkEq($sformatf("busy@%0d", cyc), busy, eBusy);
      checkEq($sformatf("ready@%0d", cyc), ifc.ready, eReady);
      mD = (clockDivisor == 24'd0) ? 1 : int'(clockDivisor);
      if (ifc.sendReq && eReady) begin
        mW = 5 + int'(dataBits);
        mPx = 1'b0;
        mBits = {};
        mBits.push_back(1'b0);
        for (int i = 0; i < mW; i++) begin
          mBits.push_back(ifc.dataIn[i]);
          mPx ^= ifc.dataIn[i];
        end
        if (hasParity) begin
          case (parityMode)
            2'd0: mBits.push_back(mPx);
            2'd1: mBits.push_back(~mPx);
            2'd2: mBits.push_back(1'b1);
            default: mBits.push_back(1'b0);
          endcase
        end
        mBits.push_back(1'b1);
        if (extraStopBit) mBits.push_back(1'b1);
        mS = (cyc + 2 > frameEnd) ? cyc + 2 : frameEnd;
        foreach (mBits[k]) begin
          for (int j = 0; j < mD; j++) begin
            expTx[mS + k * mD + j] = mBits[k];
            expBusy[mS + k * mD + j] = 1'b1;
          end
        end
        frameEnd = mS + mBits.size() * mD;
        holdUntil = mS;
      end
`ifdef UART_TX_BREAK_EN
      if (sendBreak && cyc >= frameEnd && cyc >= holdUntil) begin
        mN = (7 + int'(dataBits) + int'(hasParity) + int'(extraStopBit)) * mD;
        for (int j = 1; j <= mN + mD; j++) begin
          expTx[cyc + j] = (j > mN);
          expBusy[cyc + j] = 1'b1;
        end
        frameEnd = cyc + mN + mD + 1;
      end
`endif
    end
  end

  task automatic waitCycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns the cycle in which the character was accepted.
  task automatic sendByte(input logic [7:0] d, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    ifc.sendReq = 1'b1;
    ifc.dataIn = d;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (ifc.ready) begin
        acc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    ifc.sendReq = 1'b0;
    checkEq("accept", {31'd0, done}, 32'd1);
  endtask

  function automatic int countVal(input int which, input int from, input int to, input logic v);
    int n = 0;
    for (int c = from; c <= to && c < LOGN; c++) begin
      if (which == 0 && txLog[c] === v) n++;
      if (which == 1 && busyLog[c] === v) n++;
      if (which == 2 && readyLog[c] === v) n++;
    end
    return n;
  endfunction

  function automatic int lowRun(input int from);
    int k = 0;
    while (from + k < LOGN && txLog[from + k] === 1'b0) k++;
    return k;
  endfunction

  function automatic void setCfg(input int div, input logic [1:0] b, input logic p,
                                 input logic [1:0] m, input logic s);
    clockDivisor = 24'(div);
    dataBits = b;
    hasParity = p;
    parityMode = m;
    extraStopBit = s;
  endfunction

  typedef struct {
    int         div;
    logic [1:0] bits;
    logic       par;
    logic [1:0] mode;
    logic       stop;
    logic [7:0] data;
  } vec_t;

  vec_t vecs [5] = '{
    '{3, 2'd1, 1'b1, 2'd1, 1'b0, 8'h2A},
    '{2, 2'd1, 1'b1, 2'd2, 1'b1, 8'h15},
    '{1, 2'd3, 1'b1, 2'd3, 1'b0, 8'hC3},
    '{5, 2'd2, 1'b0, 2'd0, 1'b1, 8'h7F},
    '{2, 2'd0, 1'b1, 2'd0, 1'b1, 8'hF6}
  };

  int n, n2, s, r, b;
  logic [7:0] packed8;
  logic [6:0] packed7;

  initial begin
    rst = 1'b0;
    ifc.sendReq = 1'b0;
    ifc.dataIn = 8'd0;
    sendBreak = 1'b0;
    setCfg(10, 2'd3, 1'b0, 2'd0, 1'b0);
    #1 rst = 1'b1;
    #2;
    checkEq("reset tx", tx, 1'b1);
    checkEq("reset ready", ifc.ready, 1'b1);
    checkEq("reset busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 8N1, divisor 10, 0x55
    sendByte(8'h55, n);
    s = n + 2;
    waitCycles(120);
    checkEq("t1 tx before start", txLog[s - 1], 1'b1);
    checkEq("t1 start length", lowRun(s), 10);
    for (int k = 0; k < 8; k++) packed8[k] = txLog[s + 10 * (k + 1) + 5];
    checkEq("t1 data bits", packed8, 8'b0101_0101);
    checkEq("t1 stop bit", txLog[s + 95], 1'b1);
    checkEq("t1 busy clocks", countVal(1, n, n + 119, 1'b1), 100);

    // 7 bits, parity, two stops, divisor 4, 0x03
    setCfg(4, 2'd2, 1'b1, 2'd0, 1'b1);
    sendByte(8'h03, n);
    s = n + 2;
    waitCycles(60);
    checkEq("t2 even parity", txLog[s + 8 * 4 + 1], 1'b0);
    checkEq("t2 frame clocks", countVal(1, n, n + 59, 1'b1), 44);
    parityMode = 2'd1;
    sendByte(8'h03, n);
    s = n + 2;
    waitCycles(60);
    checkEq("t2 odd parity", txLog[s + 8 * 4 + 1], 1'b1);
    checkEq("t2 odd frame clocks", countVal(1, n, n + 59, 1'b1), 44);

    // back-to-back 0xA5, 0x3C
    setCfg(10, 2'd3, 1'b0, 2'd0, 1'b0);
    sendByte(8'hA5, n);
    sendByte(8'h3C, n2);
    waitCycles(230);
    checkEq("t3 second accept cycle", n2 - n, 2);
    checkEq("t3 first stop", txLog[n + 101], 1'b1);
    checkEq("t3 second start low run", lowRun(n + 102), 30);
    checkEq("t3 busy clocks", countVal(1, n, n + 229, 1'b1), 200);
    checkEq("t3 ready low clocks", countVal(2, n, n + 229, 1'b0), 100);

    // divisor 0, 5N1
    setCfg(0, 2'd0, 1'b0, 2'd0, 1'b0);
    sendByte(8'h1F, n);
    s = n + 2;
    waitCycles(12);
    for (int k = 0; k < 7; k++) packed7[k] = txLog[s + k];
    checkEq("t4 0x1F bits", packed7, 7'b111_1110);
    checkEq("t4 busy clocks", countVal(1, n, n + 11, 1'b1), 7);
    sendByte(8'hE0, n);
    s = n + 2;
    waitCycles(12);
    for (int k = 0; k < 7; k++) packed7[k] = txLog[s + k];
    checkEq("t4 0xE0 bits", packed7, 7'b100_0000);

    // mixed framings, checked by the timeline model
    foreach (vecs[i]) begin
      setCfg(vecs[i].div, vecs[i].bits, vecs[i].par, vecs[i].mode, vecs[i].stop);
      sendByte(vecs[i].data, n);
      waitCycles(vecs[i].div * 13 + 5);
    end

    // async reset in the middle of a data bit
    setCfg(10, 2'd3, 1'b0, 2'd0, 1'b0);
    sendByte(8'h00, n);
    waitCycles(36);
    checkEq("t5 tx low before reset", tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkEq("t5 reset tx", tx, 1'b1);
    checkEq("t5 reset ready", ifc.ready, 1'b1);
    checkEq("t5 reset busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    r = cyc;
    sendByte(8'h96, n);
    checkEq("t5 first accept after reset", n - r, 0);
    waitCycles(110);
    checkEq("t5 low run", lowRun(n + 2), 20);
    checkEq("t5 busy clocks", countVal(1, n, n + 109, 1'b1), 100);

    // line break request, 30 clocks
    sendBreak = 1'b1;
    b = cyc;
    waitCycles(30);
    sendBreak = 1'b0;
    waitCycles(100);
`ifdef UART_TX_BREAK_EN
    checkEq("t6 break low clocks", countVal(0, b, b + 129, 1'b0), 100);
    checkEq("t6 break high after", countVal(0, b + 101, b + 110, 1'b1), 10);
    checkEq("t6 break busy clocks", countVal(1, b, b + 129, 1'b1), 110);
`else
    checkEq("t6 break low clocks", countVal(0, b, b + 129, 1'b0), 0);
    checkEq("t6 break busy clocks", countVal(1, b, b + 129, 1'b1), 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
